// File: rtl/delay_pipe_elastic.sv
// Elastic N-stage, W-bit delay pipeline with valid/accept flow control and bubble collapse.
// Optional synchronous flush input is enabled by defining DELAY_PIPE_ELASTIC_FLUSH_EN.
module delay_pipe_elastic #(
  parameter int N  = 5,
  parameter int W  = 32,
  localparam int OW = (N < 1) ? 1 : $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in,
  input  logic          in_vld,
  output logic          in_rdy,
  output logic [W-1:0]  out_r,
  output logic          out_vld_r,
  input  logic          out_accept,
  output logic [OW-1:0] occ_r
`ifdef DELAY_PIPE_ELASTIC_FLUSH_EN
  ,
  input  logic          flush
`endif
);

  logic flush_i;
`ifdef DELAY_PIPE_ELASTIC_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  if (N == 0) begin : g_pass
    assign out_r     = in;
    assign out_vld_r = in_vld;
    assign in_rdy    = out_accept;
    assign occ_r     = '0;
  end else begin : g_pipe
    logic [N-1:0] vld_r;
    logic [N-1:0] adv;
    logic [N-1:0] move_in;
    logic [W-1:0] dat_r [N];
    logic         in_rdy_c;
    logic         in_fire;

    // Ready ripples from the output stage back to stage 0; a stage may move
    // if the stage ahead is empty or itself moving.
    always_comb begin
      logic path;
      logic a;
      // NOTE: blocking assignments here are intentional: 'path' carries the
      // ready chain stage to stage within one evaluation.
      path = out_accept & ~flush_i;
      a    = 1'b0;
      adv  = '0;
      for (int i = N - 1; i >= 0; i--) begin
        a      = vld_r[i] & path & ~flush_i;
        adv[i] = a;
        path   = ~vld_r[i] | a;
      end
      in_rdy_c = path & ~flush_i;
    end

    assign in_rdy  = in_rdy_c;
    assign in_fire = in_vld & in_rdy_c;

    always_comb begin
      move_in    = '0;
      move_in[0] = in_fire;
      for (int i = 1; i < N; i++) move_in[i] = adv[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_r <= '0;
        occ_r <= '0;
        // NOTE: the data registers are reset too so out_r reads 0 after reset;
        // elsewhere they only load when an item moves in.
        for (int i = 0; i < N; i++) dat_r[i] <= '0;
      end else begin
        for (int i = 0; i < N; i++)
          vld_r[i] <= ~flush_i & (move_in[i] | (vld_r[i] & ~adv[i]));
        if (move_in[0]) dat_r[0] <= in;
        for (int i = 1; i < N; i++)
          if (move_in[i]) dat_r[i] <= dat_r[i-1];
        if (flush_i)
          occ_r <= '0;
        else if (in_fire & ~adv[N-1])
          occ_r <= occ_r + OW'(1);
        else if (~in_fire & adv[N-1])
          occ_r <= occ_r - OW'(1);
      end
    end

    assign out_r     = dat_r[N-1];
    assign out_vld_r = vld_r[N-1];
  end

endmodule

// File: tb/tb_delay_pipe_elastic.sv
// Directed and scoreboard bench for delay_pipe_elastic (N=5 pipe plus an N=0 passthrough).
module tb_delay_pipe_elastic;
  localparam int N = 5;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         in_vld;
  logic         in_rdy;
  logic [W-1:0] out_r;
  logic         out_vld_r;
  logic         out_accept;
  logic [2:0]   occ_r;
`ifdef DELAY_PIPE_ELASTIC_FLUSH_EN
  logic         flush;
  logic         p_flush;
`endif

  logic [W-1:0] p_in;
  logic         p_vld;
  logic         p_rdy;
  logic [W-1:0] p_out;
  logic         p_ovld;
  logic         p_acc;
  logic [0:0]   p_occ;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  delay_pipe_elastic #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in(din), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_r(out_r), .out_vld_r(out_vld_r), .out_accept(out_accept), .occ_r(occ_r)
`ifdef DELAY_PIPE_ELASTIC_FLUSH_EN
    , .flush(flush)
`endif
  );

  delay_pipe_elastic #(.N(0), .W(W)) dut0 (
    .clk(clk), .rst(rst), .in(p_in), .in_vld(p_vld), .in_rdy(p_rdy),
    .out_r(p_out), .out_vld_r(p_ovld), .out_accept(p_acc), .occ_r(p_occ)
`ifdef DELAY_PIPE_ELASTIC_FLUSH_EN
    , .flush(p_flush)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = '0; in_vld = 1'b0; out_accept = 1'b0;
    p_in = '0; p_vld = 1'b0; p_acc = 1'b0;
`ifdef DELAY_PIPE_ELASTIC_FLUSH_EN
    flush = 1'b0; p_flush = 1'b0;
`endif
    step(); step();
    total++; if (out_vld_r !== 1'b0) $display("FAIL reset_out_vld got %b want 0", out_vld_r); else passed++;
    total++; if (occ_r !== 3'd0) $display("FAIL reset_occ got %0d want 0", occ_r); else passed++;
    total++; if (in_rdy !== 1'b1) $display("FAIL reset_in_rdy got %b want 1", in_rdy); else passed++;
    total++; if (out_r !== 32'h0) $display("FAIL reset_out_r got %h want 0", out_r); else passed++;
    rst = 1'b0;
    step();
    total++; if (in_rdy !== 1'b1 || occ_r !== 3'd0) $display("FAIL post_reset_idle got rdy=%b occ=%0d want 1/0", in_rdy, occ_r); else passed++;
  endtask

  task automatic test_back_to_back();
    int first = -1, beats = 0, bad = 0, maxocc = 0, rdy_bad = 0;
    logic [W-1:0] exp_v = 32'h1;
    out_accept = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_vld = (c < 16);
      din    = W'(c + 1);
      if (in_vld && !in_rdy) rdy_bad++;
      step();
      if (out_vld_r) begin
        if (first < 0) first = c + 1;
        if (out_r !== exp_v) bad++;
        exp_v++;
        beats++;
      end
      if (int'(occ_r) > maxocc) maxocc = int'(occ_r);
    end
    in_vld = 1'b0;
    total++; if (first !== N) $display("FAIL b2b_latency got %0d want %0d", first, N); else passed++;
    total++; if (beats !== 16) $display("FAIL b2b_beats got %0d want 16", beats); else passed++;
    total++; if (bad !== 0) $display("FAIL b2b_data got %0d wrong beats want 0", bad); else passed++;
    total++; if (rdy_bad !== 0) $display("FAIL b2b_in_rdy got %0d stalls want 0", rdy_bad); else passed++;
    total++; if (maxocc !== N) $display("FAIL b2b_occ_peak got %0d want %0d", maxocc, N); else passed++;
    total++; if (occ_r !== 3'd0 || out_vld_r !== 1'b0) $display("FAIL b2b_empty got occ=%0d vld=%b want 0/0", occ_r, out_vld_r); else passed++;
  endtask

  task automatic test_full_stall();
    int rdy_bad = 0, bad = 0;
    out_accept = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_vld = 1'b1; din = 32'hA0 + W'(i);
      if (!in_rdy) rdy_bad++;
      step();
    end
    din = 32'hA5;
    #1;
    total++; if (rdy_bad !== 0) $display("FAIL full_fill_rdy got %0d stalls want 0", rdy_bad); else passed++;
    total++; if (occ_r !== 3'd5) $display("FAIL full_occ got %0d want 5", occ_r); else passed++;
    total++; if (in_rdy !== 1'b0) $display("FAIL full_in_rdy got %b want 0", in_rdy); else passed++;
    total++; if (out_vld_r !== 1'b1 || out_r !== 32'hA0) $display("FAIL full_head got vld=%b data=%h want 1/a0", out_vld_r, out_r); else passed++;
    step();
    total++; if (occ_r !== 3'd5 || out_r !== 32'hA0) $display("FAIL full_blocked got occ=%0d data=%h want 5/a0", occ_r, out_r); else passed++;
    out_accept = 1'b1;
    #1;
    total++; if (in_rdy !== 1'b1) $display("FAIL full_accept_rdy got %b want 1", in_rdy); else passed++;
    step();
    out_accept = 1'b0; in_vld = 1'b0;
    #1;
    total++; if (occ_r !== 3'd5 || out_r !== 32'hA1) $display("FAIL full_swap got occ=%0d data=%h want 5/a1", occ_r, out_r); else passed++;
    out_accept = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (out_vld_r !== 1'b1 || out_r !== 32'hA1 + W'(k)) bad++;
      step();
    end
    out_accept = 1'b0;
    total++; if (bad !== 0) $display("FAIL full_drain got %0d wrong beats want 0", bad); else passed++;
    total++; if (occ_r !== 3'd0 || out_vld_r !== 1'b0 || out_r !== 32'hA5) $display("FAIL full_empty got occ=%0d vld=%b data=%h want 0/0/a5", occ_r, out_vld_r, out_r); else passed++;
  endtask

  task automatic test_bubble();
    out_accept = 1'b0;
    in_vld = 1'b1; din = 32'h1; step();
    in_vld = 1'b0; step(); step();
    in_vld = 1'b1; din = 32'h2; step();
    in_vld = 1'b0;
    repeat (4) step();
    total++; if (occ_r !== 3'd2 || out_vld_r !== 1'b1 || out_r !== 32'h1) $display("FAIL bubble_packed got occ=%0d vld=%b data=%h want 2/1/1", occ_r, out_vld_r, out_r); else passed++;
    out_accept = 1'b1; step(); out_accept = 1'b0;
    total++; if (occ_r !== 3'd1 || out_vld_r !== 1'b1 || out_r !== 32'h2) $display("FAIL bubble_second got occ=%0d vld=%b data=%h want 1/1/2", occ_r, out_vld_r, out_r); else passed++;
    out_accept = 1'b1; step(); out_accept = 1'b0;
    total++; if (occ_r !== 3'd0 || out_vld_r !== 1'b0 || out_r !== 32'h2) $display("FAIL bubble_empty got occ=%0d vld=%b data=%h want 0/0/2", occ_r, out_vld_r, out_r); else passed++;
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    logic [W-1:0] exp_v;
    bit hold = 1'b0;
    bit exp_rdy;
    int maxocc = 0;
    for (int c = 0; c < 10012; c++) begin
      if (c < 10000) begin
        if (!hold) begin in_vld = ($urandom_range(0, 3) != 0); din = $urandom; end
        out_accept = ((c / 500) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      end else begin
        in_vld = 1'b0; out_accept = 1'b1;
      end
      #1;
      exp_rdy = (q.size() < N) || out_accept;
      total++; if (in_rdy !== exp_rdy) $display("FAIL rand_in_rdy cyc %0d got %b want %b", c, in_rdy, exp_rdy); else passed++;
      total++; if (int'(occ_r) !== q.size()) $display("FAIL rand_occ cyc %0d got %0d want %0d", c, occ_r, q.size()); else passed++;
      if (int'(occ_r) > maxocc) maxocc = int'(occ_r);
      if (out_vld_r && out_accept) begin
        exp_v = (q.size() > 0) ? q.pop_front() : 32'hx;
        total++; if (out_r !== exp_v) $display("FAIL rand_data cyc %0d got %h want %h", c, out_r, exp_v); else passed++;
      end
      if (in_vld && exp_rdy) begin
        q.push_back(din);
        hold = 1'b0;
      end else begin
        hold = in_vld;
      end
      step();
    end
    out_accept = 1'b0;
    total++; if (q.size() !== 0 || occ_r !== 3'd0) $display("FAIL rand_drain got occ=%0d left=%0d want 0/0", occ_r, q.size()); else passed++;
    total++; if (maxocc > N) $display("FAIL rand_occ_max got %0d want <=%0d", maxocc, N); else passed++;
  endtask

  task automatic test_mid_reset();
    int beats = 0;
    out_accept = 1'b0;
    for (int i = 0; i < 3; i++) begin in_vld = 1'b1; din = 32'hB0 + W'(i); step(); end
    in_vld = 1'b0;
    total++; if (occ_r !== 3'd3) $display("FAIL mrst_pre_occ got %0d want 3", occ_r); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (out_vld_r !== 1'b0 || occ_r !== 3'd0 || in_rdy !== 1'b1) $display("FAIL mrst_immediate got vld=%b occ=%0d rdy=%b want 0/0/1", out_vld_r, occ_r, in_rdy); else passed++;
    total++; if (out_r !== 32'h0) $display("FAIL mrst_data got %h want 0", out_r); else passed++;
    step(); step();
    rst = 1'b0;
    out_accept = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (out_vld_r) beats++;
    end
    out_accept = 1'b0;
    total++; if (beats !== 0) $display("FAIL mrst_stale got %0d beats want 0", beats); else passed++;
  endtask

`ifdef DELAY_PIPE_ELASTIC_FLUSH_EN
  task automatic test_flush();
    int beats = 0;
    out_accept = 1'b0;
    for (int i = 0; i < 4; i++) begin in_vld = 1'b1; din = 32'hC0 + W'(i); step(); end
    total++; if (occ_r !== 3'd4) $display("FAIL flush_pre_occ got %0d want 4", occ_r); else passed++;
    flush = 1'b1; in_vld = 1'b1; din = 32'hC4; out_accept = 1'b1;
    #1;
    total++; if (in_rdy !== 1'b0) $display("FAIL flush_in_rdy got %b want 0", in_rdy); else passed++;
    step();
    flush = 1'b0; in_vld = 1'b0;
    total++; if (occ_r !== 3'd0 || out_vld_r !== 1'b0) $display("FAIL flush_clear got occ=%0d vld=%b want 0/0", occ_r, out_vld_r); else passed++;
    for (int c = 0; c < 8; c++) begin
      step();
      if (out_vld_r) beats++;
    end
    out_accept = 1'b0;
    total++; if (beats !== 0) $display("FAIL flush_stale got %0d beats want 0", beats); else passed++;
  endtask
`endif

  task automatic test_passthrough();
    logic [W-1:0] v_in  [4] = '{32'h12345678, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFF};
    logic         v_vld [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic         v_acc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      p_in = v_in[i]; p_vld = v_vld[i]; p_acc = v_acc[i];
      #1;
      total++; if (p_out !== v_in[i]) $display("FAIL pass_data vec %0d got %h want %h", i, p_out, v_in[i]); else passed++;
      total++; if (p_ovld !== v_vld[i]) $display("FAIL pass_vld vec %0d got %b want %b", i, p_ovld, v_vld[i]); else passed++;
      total++; if (p_rdy !== v_acc[i]) $display("FAIL pass_rdy vec %0d got %b want %b", i, p_rdy, v_acc[i]); else passed++;
      total++; if (p_occ !== 1'b0) $display("FAIL pass_occ vec %0d got %0d want 0", i, p_occ); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full_stall();
    test_bubble();
    test_random();
    test_mid_reset();
`ifdef DELAY_PIPE_ELASTIC_FLUSH_EN
    test_flush();
`endif
    test_passthrough();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
